// File: rtl/data_ram_pkg.sv
// Shared CPU constants and word type, also used by the register file and ALU.
package data_ram_pkg;

  localparam int CPU_DATA_WIDTH = 8;
  localparam int CPU_ADDR_WIDTH = 4;
  localparam int CPU_RAM_DEPTH  = 2 ** CPU_ADDR_WIDTH;

  typedef logic [CPU_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/data_ram_wr_decode.sv
// One-hot write strobe per word.
// The strobe is gated by write_enable, so an unknown address with the
// enable low can never select a word.
module data_ram_wr_decode
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH
) (
  input  logic                     write_enable,
  input  logic [ADDR_WIDTH-1:0]    address,
  output logic [2**ADDR_WIDTH-1:0] wr_sel
);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < 2 ** ADDR_WIDTH; i++) begin
      wr_sel[i] = write_enable && (address == ADDR_WIDTH'(i));
    end
  end

endmodule

// File: rtl/data_ram.sv
// Flop-based data memory for the 8-bit CPU.
// Writes are synchronous, reads are combinational, and reset clears every word.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DEPTH-1:0]      wr_sel;

  data_ram_wr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_decode (
    .write_enable (write_enable),
    .address      (address),
    .wr_sel       (wr_sel)
  );

  // Reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem[i] <= data_in;
        end
      end
    end
  end

  assign data_out = mem[address];

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: directed cases plus a randomized run
// against an array model of the memory.
module tb_data_ram;
  import data_ram_pkg::*;

  logic        clk;
  logic        rst;
  logic        write_enable;
  logic [3:0]  address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  data_ram dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string name;
    word_t exp;
    logic [3:0] addr;
  } exp_t;

  exp_t exp_q[$];
  event sample;
  int   n_checks = 0;
  int   n_pass   = 0;
  word_t model [16];

  // Monitor: compares each presented read against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(sample);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (data_out === e.exp) n_pass++;
        else $display("FAIL %s addr=%0d: data_out=%h expected=%h", e.name, e.addr, data_out, e.exp);
      end
    end
  end

  task automatic check(input logic [3:0] a, input word_t exp, input string name);
    exp_t e;
    address = a;
    e.name  = name;
    e.exp   = exp;
    e.addr  = a;
    exp_q.push_back(e);
    -> sample;
    #2;
  endtask

  // Apply inputs for one rising edge, then return to idle just after it.
  task automatic cyc(input logic r, input logic w, input logic [3:0] a, input word_t d);
    rst = r; write_enable = w; address = a; data_in = d;
    @(posedge clk);
    #1;
    rst = 1'b0; write_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_enable = 1'b0; address = '0; data_in = '0;
    @(negedge clk);

    // 1: reset clears everything
    cyc(1'b1, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) check(4'(i), 8'h00, "reset_sweep");

    // 2: basic writes
    cyc(1'b0, 1'b1, 4'd1, 8'hFF);
    cyc(1'b0, 1'b1, 4'd2, 8'hAA);
    cyc(1'b0, 1'b1, 4'd3, 8'hF0);
    check(4'd1, 8'hFF, "wr_rd_1");
    check(4'd2, 8'hAA, "wr_rd_2");
    check(4'd3, 8'hF0, "wr_rd_3");
    check(4'd0, 8'h00, "untouched_0");
    check(4'd4, 8'h00, "untouched_4");

    // 3: write_enable low holds contents, then overwrite
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'd2, 8'h55);
    check(4'd2, 8'hAA, "we_low_hold");
    cyc(1'b0, 1'b1, 4'd2, 8'h55);
    check(4'd2, 8'h55, "overwrite_2");
    check(4'd1, 8'hFF, "neighbour_1");

    // 4: reset beats a same-cycle write
    cyc(1'b1, 1'b1, 4'd5, 8'h3C);
    check(4'd5, 8'h00, "rst_over_wr_5");
    check(4'd1, 8'h00, "rst_clear_1");
    check(4'd2, 8'h00, "rst_clear_2");
    check(4'd3, 8'h00, "rst_clear_3");

    // 5: boundary addresses, combinational read follow with no edge
    cyc(1'b0, 1'b1, 4'd0, 8'h81);
    cyc(1'b0, 1'b1, 4'd15, 8'h7E);
    @(negedge clk);
    check(4'd0, 8'h81, "comb_follow_0");
    check(4'd15, 8'h7E, "comb_follow_15");
    check(4'd0, 8'h81, "comb_follow_back");

    // 6: read during write at the same address
    @(posedge clk);
    #1;
    write_enable = 1'b1; data_in = 8'h12;
    check(4'd7, 8'h00, "rdw_before");
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    check(4'd7, 8'h12, "rdw_after");

    // Randomized run against the array model
    cyc(1'b1, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int n = 0; n < 400; n++) begin
      logic        r, w;
      logic [3:0]  a;
      word_t       d;
      r = ($urandom_range(0, 39) == 0);
      w = $urandom_range(0, 1) == 1;
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      rst = r; write_enable = w; data_in = d;
      check(a, model[a], "rand_pre_edge");
      @(posedge clk);
      #1;
      rst = 1'b0; write_enable = 1'b0;
      if (r) for (int i = 0; i < 16; i++) model[i] = 8'h00;
      else if (w) model[a] = d;
      check(a, model[a], "rand_post_edge");
    end

    for (int i = 0; i < 16; i++) check(4'(i), model[i], "rand_final");

    begin
      int budget = 100;
      while (exp_q.size() > 0 && budget > 0) begin
        #1;
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
